// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, TAC tap indices and FSM states for the DMG timer
package timer_pkg;
  localparam logic [1:0] TMR_DIV  = 2'd0;
  localparam logic [1:0] TMR_TIMA = 2'd1;
  localparam logic [1:0] TMR_TMA  = 2'd2;
  localparam logic [1:0] TMR_TAC  = 2'd3;
  localparam logic [3:0] TAC_SEL_00 = 4'd9;
  localparam logic [3:0] TAC_SEL_01 = 4'd3;
  localparam logic [3:0] TAC_SEL_10 = 4'd5;
  localparam logic [3:0] TAC_SEL_11 = 4'd7;
  typedef enum logic {TMR_RUN, TMR_OVF_WAIT} tmr_state_e;
  function automatic logic [3:0] tac_sel_idx(input logic [1:0] s);
    return s == 2'b00 ? TAC_SEL_00 : s == 2'b01 ? TAC_SEL_01 : s == 2'b10 ? TAC_SEL_10 : TAC_SEL_11;
  endfunction
endpackage

// File: rtl/timer_divider.sv
// timer_divider: free-running system divider with TAC tap select and falling-edge tick
module timer_divider
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       div_wr_i,
  input  logic [2:0] tac_i,
  output logic [7:0] div_value_o,
  output logic       tick_pulse_o
);
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        tick_in, tick_q;
  assign div_cnt_d    = div_wr_i ? 16'h0000 : div_cnt_q + 16'd1;
  assign tick_in      = tac_i[2] & div_cnt_q[tac_sel_idx(tac_i[1:0])];
  // Edge detect on the gated tap keeps the DMG glitches on DIV/TAC writes
  assign tick_pulse_o = tick_q & ~tick_in;
  assign div_value_o  = div_cnt_q[15:8];
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt_q <= 16'h0000;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_in;
    end
  end
endmodule

// File: rtl/timer.sv
// timer: DMG DIV/TIMA/TMA/TAC peripheral with delayed overflow reload and irq pulse
module timer
  import timer_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE    = 16'hFF04,
  parameter int          RELOAD_DELAY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address_bus,
  inout  logic [7:0]  data_bus,
  input  logic        nread,
  input  logic        nwrite,
  input  logic        nsel,
  output logic        irq_timer
);
  localparam logic [2:0] RELOAD_CNT = 3'(RELOAD_DELAY - 1);
  tmr_state_e state_q, state_d;
  logic [7:0] tima_q, tima_d, tma_q, tma_d, div_value, rd_data;
  logic [2:0] tac_q, tac_d, cnt_q, cnt_d;
  logic       irq_q, irq_d, sel, wr, rd, tima_wr, tick;
  logic [1:0] offs;
  assign sel     = !nsel && address_bus[15:2] == ADDR_BASE[15:2];
  assign wr      = sel && !nwrite;
  assign rd      = sel && !nread;
  assign offs    = address_bus[1:0];
  assign tima_wr = wr && offs == TMR_TIMA;
  timer_divider u_div (
    .clock        (clock),
    .reset        (reset),
    .div_wr_i     (wr && offs == TMR_DIV),
    .tac_i        (tac_q),
    .div_value_o  (div_value),
    .tick_pulse_o (tick)
  );
  assign rd_data = offs == TMR_DIV ? div_value : offs == TMR_TIMA ? tima_q :
                   offs == TMR_TMA ? tma_q : {5'b11111, tac_q};
  assign data_bus  = rd ? rd_data : 8'hzz;
  assign irq_timer = irq_q;
  always_comb begin
    state_d = state_q;
    tima_d  = tima_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;
    tma_d   = (wr && offs == TMR_TMA) ? data_bus : tma_q;
    tac_d   = (wr && offs == TMR_TAC) ? data_bus[2:0] : tac_q;
    if (state_q == TMR_RUN) begin
      if (tima_wr) begin
        tima_d = data_bus;
      end else if (tick) begin
        tima_d  = tima_q == 8'hFF ? 8'h00 : tima_q + 8'd1;
        cnt_d   = tima_q == 8'hFF ? RELOAD_CNT : cnt_q;
        state_d = tima_q == 8'hFF ? TMR_OVF_WAIT : TMR_RUN;
      end
    end else if (cnt_q == 3'd0) begin
      // Reload takes the TMA value being written this clock, if any
      tima_d  = tma_d;
      irq_d   = 1'b1;
      state_d = TMR_RUN;
    end else if (tima_wr) begin
      tima_d  = data_bus;
      state_d = TMR_RUN;
    end else begin
      cnt_d = cnt_q - 3'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= TMR_RUN;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      cnt_q   <= 3'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end
endmodule
